// File: rtl/ahb3lite_master_if.sv
// ahb3lite_master_if: AHB3-Lite bus bundle between one initiator and one slave
//   master modport: drives HSEL/HADDR/HTRANS/HWRITE/HSIZE/HBURST/HPROT/HWDATA, samples HRDATA/HREADY/HRESP
//   slave modport: the mirror image
interface ahb3lite_master_if #(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32
);
  logic                  HSEL;
  logic [HADDR_SIZE-1:0] HADDR;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [3:0]            HPROT;
  logic [HDATA_SIZE-1:0] HWDATA;
  logic [HDATA_SIZE-1:0] HRDATA;
  logic                  HREADY;
  logic                  HRESP;
  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
    input  HRDATA, HREADY, HRESP
  );
  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/ahb3lite_master.sv
// ahb3lite_master: AHB3-Lite initiator turning SINGLE/INCR4/WRAP4 word commands into pipelined transfers
//   HCLK/HRESETn: clock, synchronous active-low reset
//   cmd_*: command handshake (valid/ready, direction, burst, start address, four packed write beats)
//   rd_valid/rd_data: one pulse per completed read beat; done/err: end-of-command pulses
//   bus: AHB3-Lite master side
module ahb3lite_master #(
  parameter int         HADDR_SIZE = 32,
  parameter int         HDATA_SIZE = 32,
  parameter logic [3:0] HPROT_VAL  = 4'b0011
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [1:0]              cmd_burst,
  input  logic [HADDR_SIZE-1:0]   cmd_addr,
  input  logic [4*HDATA_SIZE-1:0] cmd_wdata,
  output logic                    rd_valid,
  output logic [HDATA_SIZE-1:0]   rd_data,
  output logic                    done,
  output logic                    err,
  ahb3lite_master_if.master       bus
);
  typedef enum logic [1:0] {IDLE, ADDR, LAST, ABORT} state_t;
  localparam logic [1:0] T_IDLE = 2'b00, T_NONSEQ = 2'b10, T_SEQ = 2'b11;
  state_t state, state_n;
  logic [1:0] beat;
  logic single;
  logic [3:0][HDATA_SIZE-1:0] wbuf;
  logic accept, dp, adv, last_beat, err_start, capture, finish;
  logic [HADDR_SIZE-1:0] addr_nxt;
  assign bus.HSIZE = 3'b010;
  assign bus.HPROT = HPROT_VAL;
  // beat counts accepted address phases, so a nonzero beat in ADDR means the previous beat is in its data phase
  always_comb begin
    accept    = state == IDLE && cmd_valid && cmd_ready;
    dp        = (state == ADDR && beat != 2'd0) || state == LAST;
    err_start = dp && bus.HRESP && !bus.HREADY;
    adv       = state == ADDR && bus.HREADY;
    last_beat = single || beat == 2'd3;
    capture   = dp && bus.HREADY && !bus.HRESP && !bus.HWRITE;
    finish    = (state == LAST || state == ABORT) && bus.HREADY;
    addr_nxt  = bus.HBURST == 3'b010 ? {bus.HADDR[HADDR_SIZE-1:4], bus.HADDR[3:2] + 2'd1, 2'b00}
                                     : bus.HADDR + HADDR_SIZE'(4);
    state_n   = state;
    case (state)
      IDLE:    state_n = accept ? ADDR : IDLE;
      ADDR:    state_n = err_start ? ABORT : adv && last_beat ? LAST : ADDR;
      LAST:    state_n = err_start ? ABORT : bus.HREADY ? IDLE : LAST;
      default: state_n = bus.HREADY ? IDLE : ABORT;
    endcase
  end
  always_ff @(posedge HCLK) begin
    state <= !HRESETn ? IDLE : state_n;
  end
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      cmd_ready  <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      bus.HSEL   <= 1'b0;
      bus.HADDR  <= '0;
      bus.HTRANS <= T_IDLE;
      bus.HWRITE <= 1'b0;
      bus.HBURST <= 3'b000;
      bus.HWDATA <= '0;
      beat       <= 2'd0;
      single     <= 1'b1;
    end else begin
      cmd_ready <= state_n == IDLE;
      rd_valid  <= capture;
      done      <= finish;
      err       <= finish && state == ABORT;
      if (capture) rd_data <= bus.HRDATA;
      if (accept) begin
        bus.HSEL   <= 1'b1;
        bus.HADDR  <= {cmd_addr[HADDR_SIZE-1:2], 2'b00};
        bus.HTRANS <= T_NONSEQ;
        bus.HWRITE <= cmd_write;
        bus.HBURST <= cmd_burst == 2'd1 ? 3'b011 : cmd_burst == 2'd2 ? 3'b010 : 3'b000;
        single     <= !(cmd_burst == 2'd1 || cmd_burst == 2'd2);
        beat       <= 2'd0;
        wbuf       <= cmd_wdata;
      end else if (err_start) begin
        // first ERROR cycle: cancel the pending address phase
        bus.HSEL   <= 1'b0;
        bus.HTRANS <= T_IDLE;
      end else if (adv) begin
        bus.HWDATA <= wbuf[beat];
        beat       <= beat + 2'd1;
        bus.HSEL   <= !last_beat;
        bus.HTRANS <= last_beat ? T_IDLE : T_SEQ;
        if (!last_beat) bus.HADDR <= addr_nxt;
      end
    end
  end
endmodule
